// File: rtl/farrow_phase_scheduler.sv
// rtl/farrow_phase_scheduler.sv - Farrow resampler phase accumulator and shift/mu sequencer
//
// Purpose:
//   Keeps an exact fixed-point phase accumulator for a Farrow resampler.
//   For every output, it decides how many input samples the tap delay line
//   shifts in (o_shift_en) and which fractional offset mu the polynomial
//   evaluator receives. The mu value is passed over a valid/ready handshake.
//
// Optional feature:
//   FARROW_SCHED_STEP_LOAD_EN - adds i_step_in/i_step_wr, which load a new
//   step at run time.
//
// Ports:
//   i_clk        clock
//   i_rstn       synchronous active-low reset
//   i_enable     1 = run, 0 = pause (no new transfers started)
//   i_s_valid    input sample available
//   o_s_ready    controller accepts a sample this cycle
//   o_shift_en   delay line shifts one sample (i_s_valid & o_s_ready)
//   o_mu         fractional offset for the current output
//   o_mu_valid   mu presented to the datapath
//   i_mu_ready   datapath accepts mu (one output produced)
//   o_busy       not idle in FILL with an empty fill count
//   i_step_in    new step value, Q(INT.FRAC)   [FARROW_SCHED_STEP_LOAD_EN]
//   i_step_wr    step write strobe             [FARROW_SCHED_STEP_LOAD_EN]
module farrow_phase_scheduler #(
   parameter int FRAC_BITS = 16,
   parameter int INT_BITS  = 4,
   parameter logic [INT_BITS+FRAC_BITS-1:0] STEP = (INT_BITS+FRAC_BITS)'(1) << FRAC_BITS,
   parameter int TAPS      = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rstn,
   input  logic                          i_enable,
   input  logic                          i_s_valid,
   output logic                          o_s_ready,
   output logic                          o_shift_en,
   output logic [FRAC_BITS-1:0]          o_mu,
   output logic                          o_mu_valid,
   input  logic                          i_mu_ready,
`ifdef FARROW_SCHED_STEP_LOAD_EN
   input  logic [INT_BITS+FRAC_BITS-1:0] i_step_in,
   input  logic                          i_step_wr,
`endif
   output logic                          o_busy
);

   localparam int STEP_W = INT_BITS + FRAC_BITS;
   localparam int NEED_W = INT_BITS + 1;
   localparam int FILL_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   typedef enum logic [1:0] {
      S_FILL    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CONSUME = 2'd2
   } state_t;

   state_t              r_state;
   logic [FILL_W-1:0]   r_fill_cnt;
   logic [FRAC_BITS-1:0] r_frac;
   logic [NEED_W-1:0]   r_need;
   logic [STEP_W-1:0]   r_step;
   logic                r_mu_valid;

   logic                w_s_ready;
   logic                w_shift;
   logic                w_mu_valid;
   logic                w_mu_hs;
   logic [STEP_W-1:0]   w_step_eff;
   logic [STEP_W:0]     w_sum;
   logic [NEED_W-1:0]   w_need_nxt;

`ifdef FARROW_SCHED_STEP_LOAD_EN
   logic [STEP_W-1:0]   r_step_pend;
   logic                r_pend_vld;

   // A pending step is only ever registered, so it can affect a handshake
   // that occurs strictly after the write cycle and never an earlier one.
   assign w_step_eff = r_pend_vld ? r_step_pend : r_step;
`else
   assign w_step_eff = r_step;
`endif

   // Handshake outputs are gated by reset so that they read 0 during the
   // reset cycle itself, before the registers have been cleared.
   assign w_s_ready  = i_rstn & i_enable & ((r_state == S_FILL) | (r_state == S_CONSUME));
   assign w_shift    = w_s_ready & i_s_valid;
   assign w_mu_valid = i_rstn & r_mu_valid;
   assign w_mu_hs    = w_mu_valid & i_mu_ready;

   // One extra bit keeps the carry. The carry becomes the number of samples
   // to consume, so the phase never drifts.
   assign w_sum      = (STEP_W+1)'(r_frac) + (STEP_W+1)'(w_step_eff);
   assign w_need_nxt = w_sum[STEP_W:FRAC_BITS];

   assign o_s_ready  = w_s_ready;
   assign o_shift_en = w_shift;
   assign o_mu_valid = w_mu_valid;
   assign o_mu       = r_frac;
   assign o_busy     = (r_state != S_FILL) | (r_fill_cnt != '0);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state    <= S_FILL;
         r_fill_cnt <= '0;
         r_frac     <= '0;
         r_need     <= '0;
         r_step     <= STEP;
         r_mu_valid <= 1'b0;
`ifdef FARROW_SCHED_STEP_LOAD_EN
         r_step_pend <= '0;
         r_pend_vld  <= 1'b0;
`endif
      end else begin
         assert (w_step_eff != '0);
         case (r_state)
            S_FILL: begin
               if (w_shift) begin
                  if (r_fill_cnt == FILL_W'(TAPS - 1)) begin
                     r_fill_cnt <= '0;
                     r_state    <= S_ISSUE;
                     r_mu_valid <= 1'b1;
                  end else begin
                     r_fill_cnt <= r_fill_cnt + FILL_W'(1);
                  end
               end
            end
            S_ISSUE: begin
               if (w_mu_hs) begin
                  r_frac     <= w_sum[FRAC_BITS-1:0];
                  r_need     <= w_need_nxt;
                  r_mu_valid <= 1'b0;
                  if (w_need_nxt != '0) begin
                     r_state <= S_CONSUME;
                  end
               end else if (!r_mu_valid && i_enable) begin
                  // Upsampling: re-present mu one cycle after the previous
                  // handshake. Once valid is high, it stays high until accepted.
                  r_mu_valid <= 1'b1;
               end
            end
            S_CONSUME: begin
               if (w_shift) begin
                  r_need <= r_need - NEED_W'(1);
                  if (r_need == NEED_W'(1)) begin
                     r_state    <= S_ISSUE;
                     r_mu_valid <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_FILL;
            end
         endcase
`ifdef FARROW_SCHED_STEP_LOAD_EN
         if (w_mu_hs && r_pend_vld) begin
            r_step     <= r_step_pend;
            r_pend_vld <= 1'b0;
         end
         // This comes after the apply above. A write in the same cycle as a
         // handshake is therefore kept pending for the following handshake.
         if (i_step_wr && (i_step_in != '0)) begin
            r_step_pend <= i_step_in;
            r_pend_vld  <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_farrow_phase_scheduler.sv
// tb/tb_farrow_phase_scheduler.sv - directed self-checking bench for farrow_phase_scheduler
//
// Purpose:
//   Three instances with steps 1.0, 1.5 and 0.25 (Q4.16) are driven one at a
//   time. The bench checks fill length, mu sequences, shift counts between
//   outputs, handshake gaps, stalls, pause, reset mid-run and (when built with
//   FARROW_SCHED_STEP_LOAD_EN) run-time step loading.
//
// Ports: none (top-level bench).
module tb_farrow_phase_scheduler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rstn;
   logic [2:0]  enable;
   logic [2:0]  s_valid;
   logic [2:0]  mu_ready;
   logic [2:0]  s_ready;
   logic [2:0]  shift_en;
   logic [2:0]  mu_valid;
   logic [2:0]  busy;
   logic [15:0] mu [3];
   logic [19:0] step_in;
   logic        step_wr;

   int n_chk  = 0;
   int n_fail = 0;
   int q_mu[$];
   int q_sh[$];
   int q_gap[$];

   farrow_phase_scheduler #(.STEP(20'h10000)) u_dut0 (
      .i_clk(clk), .i_rstn(rstn[0]), .i_enable(enable[0]), .i_s_valid(s_valid[0]),
      .o_s_ready(s_ready[0]), .o_shift_en(shift_en[0]), .o_mu(mu[0]),
      .o_mu_valid(mu_valid[0]), .i_mu_ready(mu_ready[0]),
`ifdef FARROW_SCHED_STEP_LOAD_EN
      .i_step_in(step_in), .i_step_wr(step_wr),
`endif
      .o_busy(busy[0]));

   farrow_phase_scheduler #(.STEP(20'h18000)) u_dut1 (
      .i_clk(clk), .i_rstn(rstn[1]), .i_enable(enable[1]), .i_s_valid(s_valid[1]),
      .o_s_ready(s_ready[1]), .o_shift_en(shift_en[1]), .o_mu(mu[1]),
      .o_mu_valid(mu_valid[1]), .i_mu_ready(mu_ready[1]),
`ifdef FARROW_SCHED_STEP_LOAD_EN
      .i_step_in(20'h0), .i_step_wr(1'b0),
`endif
      .o_busy(busy[1]));

   farrow_phase_scheduler #(.STEP(20'h04000)) u_dut2 (
      .i_clk(clk), .i_rstn(rstn[2]), .i_enable(enable[2]), .i_s_valid(s_valid[2]),
      .o_s_ready(s_ready[2]), .o_shift_en(shift_en[2]), .o_mu(mu[2]),
      .o_mu_valid(mu_valid[2]), .i_mu_ready(mu_ready[2]),
`ifdef FARROW_SCHED_STEP_LOAD_EN
      .i_step_in(20'h0), .i_step_wr(1'b0),
`endif
      .o_busy(busy[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Inputs change at negedge+1. Outputs are sampled at negedge+2, which is
   // well away from the rising edge.
   task automatic adv();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input int k);
      rstn[k]     = 1'b0;
      enable[k]   = 1'b1;
      s_valid[k]  = 1'b1;
      mu_ready[k] = 1'b1;
      #1;
      chk($sformatf("rst%0d_s_ready", k), 32'(s_ready[k]), 0);
      chk($sformatf("rst%0d_shift_en", k), 32'(shift_en[k]), 0);
      chk($sformatf("rst%0d_mu_valid", k), 32'(mu_valid[k]), 0);
      adv();
      adv();
      rstn[k] = 1'b1;
      #1;
   endtask

   // Records each mu handshake: the mu value, the shifts since the previous
   // handshake, and the cycle gap from the previous handshake.
   task automatic collect(input int k, input int n, input int budget);
      int cnt  = 0;
      int last = -1;
      int cyc  = 0;
      q_mu.delete();
      q_sh.delete();
      q_gap.delete();
      while (q_mu.size() < n && cyc < budget) begin
         if (shift_en[k]) cnt++;
         if (mu_valid[k] && mu_ready[k]) begin
            q_mu.push_back(int'(mu[k]));
            q_sh.push_back(cnt);
            q_gap.push_back((last < 0) ? 0 : (cyc - last));
            last = cyc;
            cnt  = 0;
         end
         adv();
         cyc++;
      end
      chk($sformatf("collect%0d_count", k), 32'(q_mu.size()), 32'(n));
   endtask

   initial begin
      int e1_sh[5]  = '{4, 1, 1, 1, 1};
      int e1_gap[5] = '{0, 2, 2, 2, 2};
      int e3_mu[5]  = '{'h0, 'h8000, 'h0, 'h8000, 'h0};
      int e3_sh[5]  = '{4, 1, 2, 1, 2};
      int e3_gap[5] = '{0, 2, 3, 2, 3};
      int e4_mu[6]  = '{'h0, 'h4000, 'h8000, 'hC000, 'h0, 'h4000};
      int e4_sh[6]  = '{4, 0, 0, 0, 1, 0};
      int e4_gap[6] = '{0, 2, 2, 2, 2, 2};
      int w;

      rstn     = 3'b000;
      enable   = 3'b111;
      s_valid  = 3'b111;
      mu_ready = 3'b111;
      step_in  = 20'h0;
      step_wr  = 1'b0;
      adv();
      adv();

      // Step 1.0: fill with 4 samples, then one shift per output, mu = 0.
      do_reset(0);
      chk("t1_busy_idle", 32'(busy[0]), 0);
      chk("t1_mu_reset", 32'(mu[0]), 0);
      chk("t1_s_ready", 32'(s_ready[0]), 1);
      collect(0, 5, 40);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t1_mu%0d", i), 32'(q_mu[i]), 0);
         chk($sformatf("t1_sh%0d", i), 32'(q_sh[i]), 32'(e1_sh[i]));
         chk($sformatf("t1_gap%0d", i), 32'(q_gap[i]), 32'(e1_gap[i]));
      end
      chk("t1_busy_run", 32'(busy[0]), 1);

      // Step 1.5: mu alternates 0 / 0x8000 and the shift count alternates 1 / 2.
      do_reset(1);
      collect(1, 5, 40);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t3_mu%0d", i), 32'(q_mu[i]), 32'(e3_mu[i]));
         chk($sformatf("t3_sh%0d", i), 32'(q_sh[i]), 32'(e3_sh[i]));
         chk($sformatf("t3_gap%0d", i), 32'(q_gap[i]), 32'(e3_gap[i]));
      end

      // Step 0.25: four outputs per input and one mu every two cycles.
      do_reset(2);
      collect(2, 6, 40);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t4_mu%0d", i), 32'(q_mu[i]), 32'(e4_mu[i]));
         chk($sformatf("t4_sh%0d", i), 32'(q_sh[i]), 32'(e4_sh[i]));
         chk($sformatf("t4_gap%0d", i), 32'(q_gap[i]), 32'(e4_gap[i]));
      end

      // Stall with mu = 0x8000, then pause in CONSUME, then reset mid-CONSUME.
      do_reset(1);
      collect(1, 1, 20);
      mu_ready[1] = 1'b0;
      #1;
      w = 0;
      while (!mu_valid[1] && w < 10) begin
         adv();
         w++;
      end
      chk("t5_wait_mu_valid", 32'(mu_valid[1]), 1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            enable[1] = 1'b0;
            #1;
         end
         chk($sformatf("t5_hold_valid%0d", i), 32'(mu_valid[1]), 1);
         chk($sformatf("t5_hold_mu%0d", i), 32'(mu[1]), 32'h8000);
         chk($sformatf("t5_hold_s_ready%0d", i), 32'(s_ready[1]), 0);
         adv();
      end
      mu_ready[1] = 1'b1;
      #1;
      chk("t5_hs_valid", 32'(mu_valid[1]), 1);
      adv();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t5_pause_s_ready%0d", i), 32'(s_ready[1]), 0);
         chk($sformatf("t5_pause_shift%0d", i), 32'(shift_en[1]), 0);
         chk($sformatf("t5_pause_valid%0d", i), 32'(mu_valid[1]), 0);
         adv();
      end
      chk("t5_pause_busy", 32'(busy[1]), 1);
      enable[1] = 1'b1;
      #1;
      collect(1, 1, 20);
      chk("t5_resume_sh", 32'(q_sh[0]), 2);
      chk("t5_resume_mu", 32'(q_mu[0]), 0);
      do_reset(1);
      chk("t5_rst_busy", 32'(busy[1]), 0);
      chk("t5_rst_mu", 32'(mu[1]), 0);
      collect(1, 1, 20);
      chk("t5_refill_sh", 32'(q_sh[0]), 4);
      chk("t5_refill_mu", 32'(q_mu[0]), 0);

`ifdef FARROW_SCHED_STEP_LOAD_EN
      // Load step 2.0 during a shift cycle. A later write of 0 is ignored.
      do_reset(0);
      collect(0, 2, 20);
      step_in = 20'h20000;
      step_wr = 1'b1;
      #1;
      chk("t6_wr_shift", 32'(shift_en[0]), 1);
      adv();
      step_wr = 1'b0;
      #1;
      collect(0, 3, 30);
      chk("t6_sh0", 32'(q_sh[0]), 0);
      chk("t6_sh1", 32'(q_sh[1]), 2);
      chk("t6_sh2", 32'(q_sh[2]), 2);
      step_in = 20'h0;
      step_wr = 1'b1;
      #1;
      chk("t6_wr0_shift", 32'(shift_en[0]), 1);
      adv();
      step_wr = 1'b0;
      #1;
      collect(0, 2, 30);
      chk("t6_zero_sh0", 32'(q_sh[0]), 1);
      chk("t6_zero_sh1", 32'(q_sh[1]), 2);
      chk("t6_zero_mu1", 32'(q_mu[1]), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
